result_display_driver: RTL and testbench

- Consumer end of the exponent datapath's result/done interface.
- Accepts a binary result with a one-cycle valid pulse and converts it to BCD with a sequential double-dabble (one shift per clock).
- Latches the converted digits and drives a time-multiplexed, common-anode 7-segment display with leading-zero blanking and an overflow indication.

---
 rtl/result_display_driver_pkg.sv | 23 ++
 rtl/result_display_driver_seg7.sv | 16 +
 rtl/result_display_driver.sv | 163 ++++++++++++++++
 tb/tb_result_display_driver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_display_driver_pkg.sv
// Shared types, segment patterns and sizing helper for the result display driver.
package result_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        UPD  = 2'd2
    } state_t;

    // Active-low gfedcba segment patterns
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Decimal digits needed to hold any w-bit unsigned value (log10(2) ~ 0.301)
    function automatic int unsigned bcd_digits_for_width(input int unsigned w);
        return (w * 301) / 1000 + 1;
    endfunction

endpackage

// File: rtl/result_display_driver_seg7.sv
// Combinational BCD nibble to active-low 7-segment pattern; non-decimal nibbles blank.
module bcd_to_seg7
    import result_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg_c = SEG_DIGITS[bcd];
        end
    end

endmodule

// File: rtl/result_display_driver.sv
// Serial double-dabble converter feeding a multiplexed common-anode 7-segment display
// with leading-zero blanking and overflow dashes.
module result_display_driver
    import result_display_pkg::*;
#(
    parameter int unsigned W           = 16,
    parameter int unsigned DIGITS      = 5,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_LZ    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              result_valid,
    input  logic [W-1:0]      result,
    output logic              busy,
    output logic              conv_done,
    output logic              ovf,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int unsigned NB   = bcd_digits_for_width(W);
    localparam int unsigned BW   = NB * 4;
    localparam int unsigned SRW  = BW + W;
    localparam int unsigned PW   = ((NB > DIGITS) ? NB : DIGITS) * 4;
    localparam int unsigned DW   = DIGITS * 4;
    localparam int unsigned CNTW = $clog2(W + 1);
    localparam int unsigned RW   = $clog2(REFRESH_DIV);
    localparam int unsigned SW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t            state, state_next;
    logic [SRW-1:0]    sh, sh_step;
    logic [CNTW-1:0]   cnt;
    logic [PW-1:0]     bcd_pad;
    logic              ovf_c;
    logic [DW-1:0]     disp;
    logic [RW-1:0]     refresh;
    logic              refresh_wrap;
    logic [SW-1:0]     idx;
    logic [DIGITS-1:0] upper_zero;
    logic              zero_run;
    logic [3:0]        sel_dig;
    logic              sel_blank;
    logic [6:0]        dec_seg, seg_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (result_valid) state_next = CONV;
            CONV:    if (cnt == CNTW'(W - 1)) state_next = UPD;
            UPD:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble step: add-3 correction on every BCD nibble, then shift left
    always_comb begin
        sh_step = sh;
        for (int i = 0; i < int'(NB); i++) begin
            if (sh_step[W + i*4 +: 4] >= 4'd5) begin
                sh_step[W + i*4 +: 4] = sh_step[W + i*4 +: 4] + 4'd3;
            end
        end
        sh_step = sh_step << 1;
    end

    assign bcd_pad = PW'(sh[SRW-1:W]);
    assign ovf_c   = |(bcd_pad >> DW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh        <= '0;
            cnt       <= '0;
            disp      <= '0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            conv_done <= 1'b0;
        end else begin
            busy      <= (state != IDLE);
            conv_done <= (state == UPD);
            case (state)
                IDLE: begin
                    if (result_valid) begin
                        sh  <= SRW'(result);
                        cnt <= '0;
                    end
                end
                CONV: begin
                    sh  <= sh_step;
                    cnt <= cnt + CNTW'(1);
                end
                UPD: begin
                    disp <= bcd_pad[DW-1:0];
                    ovf  <= ovf_c;
                end
                default: ;
            endcase
        end
    end

    // upper_zero[i]: digits i..DIGITS-1 are all zero
    always_comb begin
        zero_run   = 1'b1;
        upper_zero = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_run      = zero_run & (disp[i*4 +: 4] == 4'd0);
            upper_zero[i] = zero_run;
        end
    end

    always_comb begin
        sel_dig   = '0;
        sel_blank = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx == SW'(i)) begin
                sel_dig   = disp[i*4 +: 4];
                sel_blank = upper_zero[i];
            end
        end
    end

    bcd_to_seg7 u_dec (
        .bcd   (sel_dig),
        .seg_c (dec_seg)
    );

    always_comb begin
        seg_next = dec_seg;
        if (ovf) begin
            seg_next = SEG_DASH;
        end else if ((BLANK_LZ != 0) && (idx != '0) && sel_blank) begin
            seg_next = SEG_BLANK;
        end
    end

    assign refresh_wrap = (refresh == RW'(REFRESH_DIV - 1));

    // Free-running scan; an/seg latch the current slot's digit on each wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh <= '0;
            idx     <= '0;
            an      <= '1;
            seg     <= SEG_BLANK;
        end else if (refresh_wrap) begin
            refresh <= '0;
            idx     <= (idx == SW'(DIGITS - 1)) ? '0 : idx + SW'(1);
            an      <= ~(DIGITS'(1) << idx);
            seg     <= seg_next;
        end else begin
            refresh <= refresh + RW'(1);
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench: three driver instances (5 digits, 4 digits, 5 digits without blanking).
module tb_result_display_driver;

    localparam int unsigned W = 16;
    localparam int unsigned R = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        result_valid = 1'b0;
    logic [15:0] result = '0;

    logic       busy5, done5, ovf5, dp5;
    logic [4:0] an5;
    logic [6:0] seg5;
    logic       busy4, done4, ovf4, dp4;
    logic [3:0] an4;
    logic [6:0] seg4;
    logic       busyn, donen, ovfn, dpn;
    logic [4:0] ann;
    logic [6:0] segn;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    result_display_driver #(.W(W), .DIGITS(5), .REFRESH_DIV(R), .BLANK_LZ(1)) u5 (
        .clk(clk), .rst(rst), .result_valid(result_valid), .result(result),
        .busy(busy5), .conv_done(done5), .ovf(ovf5), .an(an5), .seg(seg5), .dp(dp5));

    result_display_driver #(.W(W), .DIGITS(4), .REFRESH_DIV(R), .BLANK_LZ(1)) u4 (
        .clk(clk), .rst(rst), .result_valid(result_valid), .result(result),
        .busy(busy4), .conv_done(done4), .ovf(ovf4), .an(an4), .seg(seg4), .dp(dp4));

    result_display_driver #(.W(W), .DIGITS(5), .REFRESH_DIV(R), .BLANK_LZ(0)) un (
        .clk(clk), .rst(rst), .result_valid(result_valid), .result(result),
        .busy(busyn), .conv_done(donen), .ovf(ovfn), .an(ann), .seg(segn), .dp(dpn));

    typedef struct {
        logic [15:0] value;
        logic [34:0] s5;
        logic        o5;
        logic [27:0] s4;
        logic        o4;
        logic [34:0] sn;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Watch one full scan frame of each instance and record the pattern per digit
    task automatic capture(output logic [34:0] f5, output logic [27:0] f4, output logic [34:0] fn);
        logic [4:0] m5;
        logic [3:0] m4;
        f5 = {5{7'h55}};
        f4 = {4{7'h55}};
        fn = {5{7'h55}};
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 5; d++) begin
                m5 = 5'b1 << d;
                if (an5 == ~m5) f5[d*7 +: 7] = seg5;
                if (ann == ~m5) fn[d*7 +: 7] = segn;
            end
            for (int d = 0; d < 4; d++) begin
                m4 = 4'b1 << d;
                if (an4 == ~m4) f4[d*7 +: 7] = seg4;
            end
        end
    endtask

    task automatic check_frames(input vec_t v);
        logic [34:0] f5, fn;
        logic [27:0] f4;
        capture(f5, f4, fn);
        check($sformatf("seg5_%0d", v.value), 64'(f5), 64'(v.s5));
        check($sformatf("seg4_%0d", v.value), 64'(f4), 64'(v.s4));
        check($sformatf("segn_%0d", v.value), 64'(fn), 64'(v.sn));
        check($sformatf("ovf5_%0d", v.value), 64'(ovf5), 64'(v.o5));
        check($sformatf("ovf4_%0d", v.value), 64'(ovf4), 64'(v.o4));
    endtask

    // Pulse one result, check busy/conv_done timing, then check the displayed digits
    task automatic run_vec(input vec_t v);
        int busy_cnt, done_cnt, done_at;
        logic busy_first;
        result       = v.value;
        result_valid = 1'b1;
        @(posedge clk);
        #1 result_valid = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = 0; busy_first = 1'b0;
        for (int n = 1; n <= int'(W) + 5; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy5) busy_cnt++;
            if (n == 1) busy_first = busy5;
            if (done5) begin
                done_cnt++;
                done_at = n;
            end
        end
        check($sformatf("busy_first_%0d", v.value), 64'(busy_first), 64'd1);
        check($sformatf("busy_cycles_%0d", v.value), 64'(busy_cnt), 64'd17);
        check($sformatf("done_count_%0d", v.value), 64'(done_cnt), 64'd1);
        check($sformatf("done_at_%0d", v.value), 64'(done_at), 64'd17);
        check_frames(v);
    endtask

    initial begin
        int cnt;
        logic [4:0] exp_an;
        logic [6:0] exp_s5, exp_sn;
        int sidx;

        vecs[0] = '{16'd1234,  {7'h7F,7'h79,7'h24,7'h30,7'h19}, 1'b0, {7'h79,7'h24,7'h30,7'h19}, 1'b0, {7'h40,7'h79,7'h24,7'h30,7'h19}};
        vecs[1] = '{16'd0,     {7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, 1'b0, {7'h7F,7'h7F,7'h7F,7'h40}, 1'b0, {7'h40,7'h40,7'h40,7'h40,7'h40}};
        vecs[2] = '{16'd65535, {7'h02,7'h12,7'h12,7'h30,7'h12}, 1'b0, {7'h3F,7'h3F,7'h3F,7'h3F}, 1'b1, {7'h02,7'h12,7'h12,7'h30,7'h12}};
        vecs[3] = '{16'd9999,  {7'h7F,7'h10,7'h10,7'h10,7'h10}, 1'b0, {7'h10,7'h10,7'h10,7'h10}, 1'b0, {7'h40,7'h10,7'h10,7'h10,7'h10}};
        vecs[4] = '{16'd10000, {7'h79,7'h40,7'h40,7'h40,7'h40}, 1'b0, {7'h3F,7'h3F,7'h3F,7'h3F}, 1'b1, {7'h79,7'h40,7'h40,7'h40,7'h40}};
        vecs[5] = '{16'd100,   {7'h7F,7'h7F,7'h79,7'h40,7'h40}, 1'b0, {7'h7F,7'h79,7'h40,7'h40}, 1'b0, {7'h40,7'h40,7'h79,7'h40,7'h40}};
        vecs[6] = '{16'd59,    {7'h7F,7'h7F,7'h7F,7'h12,7'h10}, 1'b0, {7'h7F,7'h7F,7'h12,7'h10}, 1'b0, {7'h40,7'h40,7'h40,7'h12,7'h10}};
        vecs[7] = '{16'd42,    {7'h7F,7'h7F,7'h7F,7'h19,7'h24}, 1'b0, {7'h7F,7'h7F,7'h19,7'h24}, 1'b0, {7'h40,7'h40,7'h40,7'h19,7'h24}};
        vecs[8] = '{16'd500,   {7'h7F,7'h7F,7'h12,7'h40,7'h40}, 1'b0, {7'h7F,7'h12,7'h40,7'h40}, 1'b0, {7'h40,7'h40,7'h12,7'h40,7'h40}};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_an5_seg5", 64'({an5, seg5}), 64'({5'h1F, 7'h7F}));
        check("rst_flags5", 64'({busy5, done5, ovf5, dp5}), 64'(4'b0001));
        check("rst_flags_others", 64'({busy4, done4, ovf4, dp4, busyn, donen, ovfn, dpn}), 64'(8'b0001_0001));
        check("rst_an4_ann", 64'({an4, ann, seg4, segn}), 64'({4'hF, 5'h1F, 7'h7F, 7'h7F}));
        rst = 1'b0;

        // Idle scan after reset release: first drive on the 4th edge, then one digit every 4 clocks
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n < int'(R)) begin
                exp_an = 5'h1F;
                exp_s5 = 7'h7F;
                exp_sn = 7'h7F;
            end else begin
                sidx   = (n / int'(R) - 1) % 5;
                exp_an = ~(5'b1 << sidx);
                exp_s5 = (sidx == 0) ? 7'h40 : 7'h7F;
                exp_sn = 7'h40;
            end
            check($sformatf("idle_scan_%0d", n), 64'({an5, seg5, segn}), 64'({exp_an, exp_s5, exp_sn}));
        end

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Second valid while busy is ignored
        result = 16'd42; result_valid = 1'b1;
        @(posedge clk);
        #1 result_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        result = 16'd777; result_valid = 1'b1;
        @(posedge clk);
        #1 result_valid = 1'b0;
        cnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done5) cnt++;
        end
        check("busy_ignore_done_count", 64'(cnt), 64'd1);
        check_frames(vecs[7]);

        // Valid sampled in the UPD cycle is ignored
        result = 16'd1234; result_valid = 1'b1;
        @(posedge clk);
        #1 result_valid = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        result = 16'd7; result_valid = 1'b1;
        @(posedge clk);
        #1 result_valid = 1'b0;
        @(posedge clk);
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (busy5) cnt++;
            @(posedge clk);
        end
        @(negedge clk);
        check("upd_ignore_busy", 64'(cnt), 64'd0);
        check_frames(vecs[0]);

        // Reset in the middle of a conversion
        result = 16'd500; result_valid = 1'b1;
        @(posedge clk);
        #1 result_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_flags", 64'({busy5, done5, ovf5}), 64'(3'b000));
        check("midrst_an_seg", 64'({an5, seg5}), 64'({5'h1F, 7'h7F}));
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done5) cnt++;
        end
        check("midrst_no_done", 64'(cnt), 64'd0);
        check_frames(vecs[1]);
        run_vec(vecs[8]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
